// File: rtl/mem_port_arbiter.sv
// Shared line-wide memory port arbiter for the I-cache and D-cache.
// Optional macro MEM_PORT_ARB_STATS_EN builds the grant/conflict counters.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int LINE_W       = 64,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              both_pending,
  output logic [15:0]       stat_i_grants,
  output logic [15:0]       stat_d_grants,
  output logic [15:0]       stat_conflict
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP
  } state_e;

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  state_e            state_q;
  logic              own_d_q;
  logic [SW-1:0]     streak_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic              i_ack_q;
  logic              d_ack_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  logic i_elig;
  logic d_elig;
  logic take_d;
  logic take_i;

  assign i_elig = i_req & ~i_ack_q;
  assign d_elig = d_req & ~d_ack_q;
  assign take_d = (state_q == IDLE) & d_elig
                & (~i_elig | (streak_q != STREAK_MAX));
  assign take_i = (state_q == IDLE) & i_elig & ~take_d;

  // Arbitration FSM: grant, hold the memory request, pulse the owner's ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      own_d_q     <= 1'b0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (take_d) begin
            state_q     <= SERVE_D;
            own_d_q     <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            if (!i_req) begin
              streak_q <= '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_q <= streak_q + 1'b1;
            end
          end else if (take_i) begin
            state_q    <= SERVE_I;
            own_d_q    <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= i_addr;
            streak_q   <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
            if (own_d_q) begin
              d_ack_q <= 1'b1;
              if (!mem_we_q) begin
                d_rdata_q <= mem_rdata;
              end
            end else begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= mem_rdata;
            end
          end
        end
        RESP: begin
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign both_pending = ((state_q == SERVE_I) & d_req)
                      | ((state_q == SERVE_D) & i_req)
                      | ((state_q == RESP) & (own_d_q ? i_req : d_req));

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

`ifdef MEM_PORT_ARB_STATS_EN
  logic [15:0] si_q;
  logic [15:0] sd_q;
  logic [15:0] sc_q;

  // Saturating grant and conflict-cycle counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      si_q <= '0;
      sd_q <= '0;
      sc_q <= '0;
    end else begin
      if (take_i && si_q != 16'hFFFF) begin
        si_q <= si_q + 16'd1;
      end
      if (take_d && sd_q != 16'hFFFF) begin
        sd_q <= sd_q + 16'd1;
      end
      if (both_pending && sc_q != 16'hFFFF) begin
        sc_q <= sc_q + 16'd1;
      end
    end
  end

  assign stat_i_grants = si_q;
  assign stat_d_grants = sd_q;
  assign stat_conflict = sc_q;
`else
  assign stat_i_grants = '0;
  assign stat_d_grants = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a memory responder
// and a rule-level arbitration/fairness model.
module tb_mem_port_arbiter;
  localparam int AW   = 16;
  localparam int LW   = 64;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [LW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [LW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [LW-1:0] mem_rdata = '0;
  logic          both_pending;
  logic [15:0]   stat_i_grants;
  logic [15:0]   stat_d_grants;
  logic [15:0]   stat_conflict;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .both_pending(both_pending),
    .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
    .stat_conflict(stat_conflict)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } mreq_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 2;
  bit spur = 1'b0;

  logic [LW-1:0] tmem [logic [AW-1:0]];
  logic [LW-1:0] mmem [logic [AW-1:0]];
  mreq_t imq[$];
  mreq_t dmq[$];
  logic [LW-1:0] iexp[$];
  logic [LW-1:0] dexp[$];
  logic [LW-1:0] dlast_m = '0;

  int streak_m = 0;
  int igr = 0;
  int dgr = 0;
  int ncf = 0;
  int gcnt = 0;
  logic [31:0] gseq = '0;
  bit bp_servd = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] initv(logic [AW-1:0] a);
    return {a, ~a, a ^ 16'h5A5A, a + 16'd1};
  endfunction

  task automatic chk(string name, logic [LW-1:0] act, logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic i_issue(logic [AW-1:0] a);
    mreq_t m;
    i_addr = a;
    i_req  = 1'b1;
    m.we = 1'b0;
    m.addr = a;
    m.wdata = '0;
    imq.push_back(m);
    iexp.push_back(tmem.exists(a) ? tmem[a] : initv(a));
  endtask

  task automatic d_issue(logic we, logic [AW-1:0] a, logic [LW-1:0] w);
    mreq_t m;
    d_we = we;
    d_addr = a;
    d_wdata = w;
    d_req = 1'b1;
    m.we = we;
    m.addr = a;
    m.wdata = w;
    dmq.push_back(m);
    if (we) begin
      tmem[a] = w;
    end else begin
      dlast_m = tmem.exists(a) ? tmem[a] : initv(a);
    end
    dexp.push_back(dlast_m);
  endtask

  task automatic wait_ack(bit is_d, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (is_d ? d_ack : i_ack) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s_ack_timeout: got no ack expected ack", is_d ? "d" : "i");
    end
  endtask

  task automatic i_run(int n, int maxgap);
    bit ok;
    for (int k = 0; k < n; k++) begin
      int g;
      g = $urandom_range(0, maxgap);
      if (g > 0) begin
        i_req = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      i_issue({1'b0, 12'h000, 3'($urandom)});
      wait_ack(1'b0, ok);
      @(posedge clk);
      #1;
    end
    i_req = 1'b0;
  endtask

  task automatic d_run(int n, int maxgap);
    bit ok;
    for (int k = 0; k < n; k++) begin
      int g;
      g = $urandom_range(0, maxgap);
      if (g > 0) begin
        d_req = 1'b0;
        repeat (g) @(posedge clk);
        #1;
      end
      d_issue(1'($urandom), {1'b1, 12'h000, 3'($urandom)},
              {$urandom, $urandom});
      wait_ack(1'b1, ok);
      @(posedge clk);
      #1;
    end
    d_req = 1'b0;
  endtask

  task automatic chk_stats(string tag);
`ifdef MEM_PORT_ARB_STATS_EN
    chk({tag, "_stat_i"}, 64'(stat_i_grants), 64'(igr));
    chk({tag, "_stat_d"}, 64'(stat_d_grants), 64'(dgr));
    chk({tag, "_stat_c"}, 64'(stat_conflict), 64'(ncf));
`else
    chk({tag, "_stat_i"}, 64'(stat_i_grants), 64'd0);
    chk({tag, "_stat_d"}, 64'(stat_d_grants), 64'd0);
    chk({tag, "_stat_c"}, 64'(stat_conflict), 64'd0);
`endif
  endtask

  // Memory responder: acks each request `lat` cycles after it rises.
  initial begin
    int mcnt;
    bit mbusy;
    mcnt = 0;
    mbusy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (!reset_n) begin
        mbusy = 1'b0;
      end else if (mbusy) begin
        mcnt--;
        if (mcnt == 0) begin
          mbusy = 1'b0;
          mem_ack = 1'b1;
          if (mem_we) begin
            mmem[mem_addr] = mem_wdata;
            mem_rdata = {$urandom, $urandom};
          end else begin
            mem_rdata = mmem.exists(mem_addr) ? mmem[mem_addr]
                                              : initv(mem_addr);
          end
        end
      end else if (spur) begin
        spur = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end else if (mem_req) begin
        mbusy = 1'b1;
        mcnt = (lat > 0) ? lat : int'($urandom_range(1, 4));
      end
    end
  end

  // Monitor: grant order/fairness, both_pending, ack data scoreboard.
  initial begin
    bit pmreq, pi, pd, own_d;
    pmreq = 1'b0;
    pi = 1'b0;
    pd = 1'b0;
    own_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pmreq = 1'b0;
        pi = 1'b0;
        pd = 1'b0;
        streak_m = 0;
        igr = 0;
        dgr = 0;
        ncf = 0;
      end else begin
        bit ebp;
        if (mem_req && !pmreq) begin
          bit hit_d, hit_i;
          hit_d = dmq.size() > 0 && dmq[0].we == mem_we
                  && dmq[0].addr == mem_addr
                  && (!mem_we || dmq[0].wdata == mem_wdata);
          hit_i = imq.size() > 0 && !mem_we && imq[0].addr == mem_addr;
          total++;
          if (hit_d) begin
            own_d = 1'b1;
            void'(dmq.pop_front());
            dgr++;
            gcnt++;
            gseq = {gseq[30:0], 1'b1};
            if (pi && streak_m == MAXS) begin
              bad++;
              $display("FAIL fairness: got D grant expected I grant");
            end
            streak_m = pi ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
          end else if (hit_i) begin
            own_d = 1'b0;
            void'(imq.pop_front());
            igr++;
            gcnt++;
            gseq = {gseq[30:0], 1'b0};
            if (pd && streak_m < MAXS) begin
              bad++;
              $display("FAIL priority: got I grant expected D grant");
            end
            streak_m = 0;
          end else begin
            bad++;
            $display("FAIL grant_match: got we=%b addr=%h expected a queued request",
                     mem_we, mem_addr);
          end
        end
        ebp = (mem_req && !own_d && d_req) || (mem_req && own_d && i_req)
           || (i_ack && d_req) || (d_ack && i_req);
        if (ebp) ncf++;
        if (mem_req && own_d && both_pending) bp_servd = 1'b1;
        chk("both_pending", 64'(both_pending), 64'(ebp));
        if (i_ack && d_ack) chk("ack_overlap", 64'(i_ack & d_ack), 64'd0);
        if (i_ack) begin
          if (iexp.size() == 0) chk("i_ack_unexpected", 64'(i_ack), 64'd0);
          else chk("i_rdata", i_rdata, iexp.pop_front());
        end
        if (d_ack) begin
          if (dexp.size() == 0) chk("d_ack_unexpected", 64'(d_ack), 64'd0);
          else chk("d_rdata", d_rdata, dexp.pop_front());
        end
        pmreq = mem_req;
        pi = i_req && !i_ack;
        pd = d_req && !d_ack;
      end
    end
  end

  initial begin
    bit ok;
    int t0;
    tmem[16'h0040] = 64'h1111_2222_3333_4444;
    mmem[16'h0040] = 64'h1111_2222_3333_4444;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_i_ack", 64'(i_ack), 64'd0);
    chk("rst_d_ack", 64'(d_ack), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_i_rdata", i_rdata, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk_stats("rst");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    lat = 3;
    t0 = cyc;
    i_issue(16'h0040);
    wait_ack(1'b0, ok);
    chk("t1_latency", 64'(cyc - t0), 64'd5);
    chk("t1_data", i_rdata, 64'h1111_2222_3333_4444);
    chk("t1_mem_addr", 64'(mem_addr), 64'h0040);
    chk("t1_mem_we", 64'(mem_we), 64'd0);
    @(posedge clk);
    #1;
    i_req = 1'b0;

    lat = 2;
    gseq = '0;
    gcnt = 0;
    bp_servd = 1'b0;
    fork
      begin
        bit k1;
        d_issue(1'b1, 16'h0100, 64'hDEAD_BEEF_0000_0001);
        wait_ack(1'b1, k1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
      end
      begin
        bit k2;
        i_issue(16'h0044);
        wait_ack(1'b0, k2);
        @(posedge clk);
        #1;
        i_req = 1'b0;
      end
    join
    chk("t2_grant_count", 64'(gcnt), 64'd2);
    chk("t2_grant_order", 64'(gseq), 64'b10);
    chk("t2_bp_in_serve_d", 64'(bp_servd), 64'd1);

    gseq = '0;
    gcnt = 0;
    fork
      begin
        bit k3;
        i_issue(16'h0050);
        wait_ack(1'b0, k3);
        @(posedge clk);
        #1;
        i_req = 1'b0;
      end
      d_run(5, 0);
    join
    chk("t3_grant_count", 64'(gcnt), 64'd6);
    chk("t3_grant_order", 64'(gseq), 64'b111101);
    repeat (3) @(posedge clk);
    #1;
    chk_stats("t6");

    spur = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5_spur_mem_req", 64'(mem_req), 64'd0);
      chk("t5_spur_acks", 64'({i_ack, d_ack}), 64'd0);
    end
    @(posedge clk);
    #1;
    i_issue(16'h0060);
    wait_ack(1'b0, ok);
    @(posedge clk);
    #1;
    i_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5_no_regrant", 64'(mem_req), 64'd0);

    lat = 0;
    fork
      i_run(30, 3);
      d_run(30, 3);
    join
    repeat (3) @(posedge clk);
    #1;
    chk("rand_i_drained", 64'(iexp.size() + imq.size()), 64'd0);
    chk("rand_d_drained", 64'(dexp.size() + dmq.size()), 64'd0);
    chk_stats("rand");

    lat = 6;
    d_issue(1'b0, 16'h8003, '0);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t4_mem_req_seen", 64'(ok), 64'd1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t4_async_mem_req", 64'(mem_req), 64'd0);
    d_req = 1'b0;
    void'(dexp.pop_back());
    dlast_m = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t4_no_d_ack", 64'(d_ack), 64'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("t4_d_rdata_cleared", d_rdata, 64'd0);
    chk_stats("t4_rst");
    @(posedge clk);
    #1;
    lat = 2;
    d_issue(1'b0, 16'h8003, '0);
    wait_ack(1'b1, ok);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t4_d_drained", 64'(dexp.size() + dmq.size()), 64'd0);
    chk_stats("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
